// File: rtl/falafel_fit_finder.sv
// First-fit walker over the in-memory free list: returns the first block whose size
// covers the request, together with its predecessor, using one outstanding read at a time.
//
// state        | meaning
// IDLE         | waiting for a search request
// RD_SIZE_REQ  | requesting the size word of the current block
// RD_SIZE_WAIT | waiting for the size word, then fit check
// RD_NEXT_REQ  | requesting the next pointer of the current block
// RD_NEXT_WAIT | waiting for the next pointer, then end-of-list / hop-limit check
// RESP         | result presented until accepted
module falafel_fit_finder #(
    parameter int DATA_W   = 64,
    parameter int MAX_HOPS = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] free_list_ptr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_size_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [DATA_W-1:0] mem_addr_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_found_o,
    output logic [DATA_W-1:0] rsp_addr_o,
    output logic [DATA_W-1:0] rsp_prev_o,
    output logic [DATA_W-1:0] rsp_size_o,
    output logic              busy_o
);

    localparam int                HOP_W     = $clog2(MAX_HOPS + 1);
    localparam logic [HOP_W-1:0]  HOP_LIMIT = HOP_W'(MAX_HOPS);
    localparam logic [DATA_W-1:0] NEXT_OFS  = DATA_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_SIZE_REQ,
        RD_SIZE_WAIT,
        RD_NEXT_REQ,
        RD_NEXT_WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] size_q;
    logic [DATA_W-1:0] cur_q;
    logic [DATA_W-1:0] prev_q;
    logic [HOP_W-1:0]  hops_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            size_q      <= '0;
            cur_q       <= '0;
            prev_q      <= '0;
            hops_q      <= '0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_found_o <= 1'b0;
            rsp_addr_o  <= '0;
            rsp_prev_o  <= '0;
            rsp_size_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        size_q      <= req_size_i;
                        cur_q       <= free_list_ptr_i;
                        prev_q      <= '0;
                        hops_q      <= '0;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (free_list_ptr_i == '0) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_found_o <= 1'b0;
                            rsp_addr_o  <= '0;
                            rsp_prev_o  <= '0;
                            rsp_size_o  <= '0;
                        end else begin
                            state      <= RD_SIZE_REQ;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= free_list_ptr_i;
                        end
                    end
                end
                RD_SIZE_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= RD_SIZE_WAIT;
                    end
                end
                RD_SIZE_WAIT: begin
                    if (mem_rvalid_i) begin
                        hops_q <= hops_q + 1'b1;
                        if (mem_rdata_i >= size_q) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_found_o <= 1'b1;
                            rsp_addr_o  <= cur_q;
                            rsp_prev_o  <= prev_q;
                            rsp_size_o  <= mem_rdata_i;
                        end else begin
                            state      <= RD_NEXT_REQ;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= cur_q + NEXT_OFS;
                        end
                    end
                end
                RD_NEXT_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= RD_NEXT_WAIT;
                    end
                end
                RD_NEXT_WAIT: begin
                    if (mem_rvalid_i) begin
                        // hops_q already counts the block just examined
                        if (mem_rdata_i == '0 || hops_q == HOP_LIMIT) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_found_o <= 1'b0;
                            rsp_addr_o  <= '0;
                            rsp_prev_o  <= '0;
                            rsp_size_o  <= '0;
                        end else begin
                            prev_q     <= cur_q;
                            cur_q      <= mem_rdata_i;
                            state      <= RD_SIZE_REQ;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= mem_rdata_i;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_req_o   <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
